ysyx_22050039_ifu: RTL
======================

Name: ysyx_22050039_ifu

Overview:
Instruction fetch unit. It is the producer side of the instruction/PC interface that the decode stage consumes. It holds the architectural PC and issues 32-bit fetch requests to instruction memory over a valid/ready request and valid response channel. It buffers one returned instruction and presents it to decode with a valid/ready handshake, and applies PC redirects (jal, jalr, branches) from the execute stage, including killing in-flight fetches.

Parameters:
XLEN, 64, datapath/PC width
INST_LEN, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
redirect_valid  in  1  execute stage requests PC change (pc_wen)
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  instruction data returned (1-cycle pulse)
imem_rsp_data  in  INST_LEN  returned instruction
inst_valid  out  1  inst/inst_pc valid to decode
inst_ready  in  1  decode consumes inst
inst  out  INST_LEN  buffered instruction
inst_pc  out  XLEN  PC of buffered instruction
fetch_fault  out  1  held instruction is a misaligned-fetch fault (see optional feature)

Behaviour:
- Reset (async, any state): state=BOOT, pc=RESET_PC, kill=0, inst=0, inst_pc=0, inst_valid=0, imem_req_valid=0, fetch_fault=0.
- States BOOT, REQ, WAIT, HOLD. All outputs are registered except imem_req_valid=(state==REQ) and imem_req_addr=pc.
- BOOT: one cycle, no request; go to REQ. Redirect ignored.
- REQ: imem_req_valid=1, addr=pc.
  - On req_ready, go to WAIT.
  - Redirect without req_ready: pc<=redirect_pc, stay in REQ. The address may change while not accepted; memory must tolerate this.
  - Redirect with req_ready: request issues with the old pc; pc<=redirect_pc, kill<=1, go to WAIT.
- WAIT: no new request.
  - On rsp_valid with kill=0: inst<=rsp_data, inst_pc<=pc, inst_valid<=1, go to HOLD.
  - On rsp_valid with kill=1: discard, kill<=0, go to REQ.
  - Redirect in WAIT: pc<=redirect_pc, kill<=1. If it coincides with rsp_valid, the response is discarded and the state goes to REQ with kill=0.
- HOLD: inst_valid=1 and the outputs are stable until handshake.
  - inst_ready without redirect: pc<=pc+4 (wraps mod 2^XLEN), inst_valid<=0, go to REQ.
  - Redirect (with or without inst_ready): pc<=redirect_pc, inst_valid<=0, go to REQ. Redirect has priority over the +4 update.
- Throughput: at most one fetch outstanding. Minimum fetch-to-valid latency is 2 cycles after entering REQ with req_ready=1 and a 1-cycle response.
- rsp_valid outside WAIT is ignored.
- Back-to-back redirects: the last one wins; kill stays a single bit because only one request is ever outstanding.

Optional Feature:
YSYX_22050039_IFU_MISALIGN_EN
- Defined:
  - In REQ, if pc[1:0]!=0, no request is issued (imem_req_valid=0).
  - Next cycle: HOLD with inst=32'h0000_0013, inst_pc=pc, fetch_fault=1, inst_valid=1.
  - fetch_fault clears when leaving HOLD.
  - Redirect in that REQ cycle takes priority: pc<=redirect_pc, no fault.
- Undefined: imem_req_addr={pc[XLEN-1:2],2'b00}, and fetch_fault is tied 0.

Test Plan:
- Reset then idle memory (req_ready=1, rsp 1 cycle later with 32'h00000413) -> req_valid first at cycle 2 with addr 0x80000000; inst_valid with inst=0x00000413, inst_pc=0x80000000; after inst_ready the next addr is 0x80000004.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable and no new request; on ready the next addr is pc+4.
- Redirect to 0x80000100 during WAIT, then rsp 0xDEADBEEF arrives -> response dropped, inst_valid stays 0; next request addr 0x80000100.
- Redirect to 0x80000200 in the same cycle as req handshake at 0x80000008 -> stale response discarded; next addr 0x80000200; delivered inst_pc=0x80000200.
- Redirect plus inst_ready in HOLD at pc 0x80000010 to target 0x80000040 -> next addr 0x80000040, not 0x80000014; also pc=0xFFFF_FFFF_FFFF_FFFC with +4 -> wraps to 0.
- With macro: redirect to 0x80000002 -> no imem request; inst_valid with fetch_fault=1, inst=0x00000013, inst_pc=0x80000002. Without macro: request addr 0x80000000 and fetch_fault=0. Assert rst mid-WAIT -> all outputs return to reset values immediately; first request at 0x80000000.

Source files
------------

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: owns the PC, fetches one 32-bit word at a time and hands it to decode.
// Optional misaligned-fetch fault generation is enabled with `define YSYX_22050039_IFU_MISALIGN_EN.
module ysyx_22050039_ifu #(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  output logic                fetch_fault
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  localparam logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0]     PC_STEP  = {{(XLEN-3){1'b0}}, 3'd4};

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                kill_q, kill_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic                fault_q, fault_d;
  logic                misalign_s;

`ifdef YSYX_22050039_IFU_MISALIGN_EN
  assign misalign_s    = (pc_q[1:0] != 2'b00);
  assign imem_req_addr = pc_q;
  assign fetch_fault   = fault_q;
`else
  assign misalign_s    = 1'b0;
  assign imem_req_addr = {pc_q[XLEN-1:2], 2'b00};
  assign fetch_fault   = 1'b0;
`endif

  assign imem_req_valid = (state_q == S_REQ) && !misalign_s;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  // Next-state and datapath update for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          // A redirect racing an accepted request leaves one stale response to drop.
          pc_d = redirect_pc;
          if (imem_req_ready && !misalign_s) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end else if (misalign_s) begin
          state_d      = S_HOLD;
          inst_d       = NOP_INST;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          fault_d      = 1'b1;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          inst_valid_d = 1'b0;
          fault_d      = 1'b0;
          state_d      = S_REQ;
        end else if (inst_ready) begin
          pc_d         = pc_q + PC_STEP;
          inst_valid_d = 1'b0;
          fault_d      = 1'b0;
          state_d      = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

endmodule
